// File: rtl/kgp_add_sched.sv
// Round-robin scheduler that shares one 8-bit kill/generate/propagate adder
// between NREQ requesters and runs byte-serial, LSB-first multi-byte additions.

module KGP_adder (
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   input  logic       cin_i,
   output logic [7:0] sum_o,
   output logic       cout_o
);
   function automatic logic [8:0] kgp_add(input logic [7:0] a, input logic [7:0] b,
                                          input logic cin);
      logic [7:0] g;
      logic [7:0] p;
      logic [8:0] c;
      g    = a & b;
      p    = a ^ b;
      c    = '0;
      c[0] = cin;
      for (int i = 0; i < 8; i++) c[i+1] = g[i] | (p[i] & c[i]);
      return {c[8], p ^ c[7:0]};
   endfunction

   assign {cout_o, sum_o} = kgp_add(a_i, b_i, cin_i);
endmodule

module kgp_add_sched #(
   parameter int NREQ   = 4,
   parameter int NBYTES = 4,
   parameter int IDW    = $clog2(NREQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*8*NBYTES-1:0] req_a,
   input  logic [NREQ*8*NBYTES-1:0] req_b,
   input  logic [NREQ-1:0]          req_cin,
   output logic [NREQ-1:0]          req_ready,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [IDW-1:0]           rsp_id,
   output logic [8*NBYTES-1:0]      rsp_sum,
   output logic                     rsp_cout,
   output logic                     busy
);
   localparam int W    = 8 * NBYTES;
   localparam int CNTW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [CNTW-1:0] LAST = CNTW'(NBYTES - 1);

   typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;

   state_t          state_q, state_d;
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [IDW-1:0]  id_q, id_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            carry_q, carry_d;
   logic            cout_q, cout_d;
   logic [W-1:0]    sum_q, sum_d;
   logic [W-1:0]    a_q, b_q;

   logic            gnt_found, grant;
   logic [IDW-1:0]  gnt_idx;
   logic [W-1:0]    a_sel, b_sel;
   logic            cin_sel;
   logic [7:0]      a_byte, b_byte, add_sum;
   logic            add_cout;

   // First valid requester at or above ptr, else the lowest one (wrap-around).
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (!gnt_found && req_valid[j] && (IDW'(j) >= ptr_q)) begin
            gnt_found = 1'b1;
            gnt_idx   = IDW'(j);
         end
      end
      for (int j = 0; j < NREQ; j++) begin
         if (!gnt_found && req_valid[j]) begin
            gnt_found = 1'b1;
            gnt_idx   = IDW'(j);
         end
      end
   end

   assign grant     = (state_q == IDLE) && gnt_found && !rst;
   assign req_ready = grant ? (NREQ'(1) << gnt_idx) : '0;

   always_comb begin
      a_sel   = '0;
      b_sel   = '0;
      cin_sel = 1'b0;
      for (int j = 0; j < NREQ; j++) begin
         if (gnt_idx == IDW'(j)) begin
            a_sel   = req_a[W*j +: W];
            b_sel   = req_b[W*j +: W];
            cin_sel = req_cin[j];
         end
      end
   end

   always_comb begin
      a_byte = '0;
      b_byte = '0;
      for (int n = 0; n < NBYTES; n++) begin
         if (cnt_q == CNTW'(n)) begin
            a_byte = a_q[8*n +: 8];
            b_byte = b_q[8*n +: 8];
         end
      end
   end

   KGP_adder u_add (
      .a_i   (a_byte),
      .b_i   (b_byte),
      .cin_i (carry_q),
      .sum_o (add_sum),
      .cout_o(add_cout)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      sum_d   = sum_q;
      case (state_q)
         IDLE: begin
            if (grant) begin
               carry_d = cin_sel;
               id_d    = gnt_idx;
               ptr_d   = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
               cnt_d   = '0;
               state_d = ADD;
            end
         end
         ADD: begin
            for (int n = 0; n < NBYTES; n++) begin
               if (cnt_q == CNTW'(n)) sum_d[8*n +: 8] = add_sum;
            end
            carry_d = add_cout;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               cout_d  = add_cout;
               cnt_d   = '0;
               state_d = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         id_q    <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         sum_q   <= sum_d;
      end
   end

   // Operands are only meaningful after a grant, so they carry no reset.
   always_ff @(posedge clk) begin
      if (grant) begin
         a_q <= a_sel;
         b_q <= b_sel;
      end
   end

   assign rsp_valid = (state_q == RESP);
   assign busy      = (state_q != IDLE);
   assign rsp_id    = id_q;
   assign rsp_sum   = sum_q;
   assign rsp_cout  = cout_q;
endmodule

// File: tb/tb_kgp_add_sched.sv
// Bench for kgp_add_sched: directed vectors and corner sequences on a 4-byte
// instance, then randomized traffic on 4-byte and 1-byte instances side by side.

module tb_kgp_add_sched;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  rv   [2];
   logic [31:0] opa  [2][4];
   logic [31:0] opb  [2][4];
   logic [3:0]  cin  [2];
   logic        rr   [2];

   logic [3:0]  rdy4, rdy1;
   logic        vld4, vld1;
   logic [1:0]  id4, id1;
   logic [31:0] sum4;
   logic [7:0]  sum1;
   logic        cout4, cout1, busy4, busy1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0]  mask;
      int          gid;
      logic [31:0] a;
      logic [31:0] b;
      logic        ci;
      logic [31:0] es;
      logic        ec;
   } vec_t;

   vec_t tbl [5];

   int          m_ptr [2];
   bit          pend  [2];
   int          pid   [2];
   logic [32:0] pexp  [2];
   int          gcyc  [2];
   int          ngr   [2];
   int          nrs   [2];
   logic [3:0]  seen  [2];

   always #5 clk = ~clk;

   kgp_add_sched #(.NREQ(4), .NBYTES(4)) u_dut4 (
      .clk      (clk),
      .rst      (rst),
      .req_valid(rv[0]),
      .req_a    ({opa[0][3], opa[0][2], opa[0][1], opa[0][0]}),
      .req_b    ({opb[0][3], opb[0][2], opb[0][1], opb[0][0]}),
      .req_cin  (cin[0]),
      .req_ready(rdy4),
      .rsp_valid(vld4),
      .rsp_ready(rr[0]),
      .rsp_id   (id4),
      .rsp_sum  (sum4),
      .rsp_cout (cout4),
      .busy     (busy4)
   );

   kgp_add_sched #(.NREQ(4), .NBYTES(1)) u_dut1 (
      .clk      (clk),
      .rst      (rst),
      .req_valid(rv[1]),
      .req_a    ({opa[1][3][7:0], opa[1][2][7:0], opa[1][1][7:0], opa[1][0][7:0]}),
      .req_b    ({opb[1][3][7:0], opb[1][2][7:0], opb[1][1][7:0], opb[1][0][7:0]}),
      .req_cin  (cin[1]),
      .req_ready(rdy1),
      .rsp_valid(vld1),
      .rsp_ready(rr[1]),
      .rsp_id   (id1),
      .rsp_sum  (sum1),
      .rsp_cout (cout1),
      .busy     (busy1)
   );

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Golden sum: plain integer addition truncated to the operand width.
   function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic ci, input int nb);
      logic [63:0] m;
      logic [63:0] t;
      m = (64'd1 << (8 * nb)) - 64'd1;
      t = ({32'd0, a} & m) + ({32'd0, b} & m) + {63'd0, ci};
      return {t[8*nb], t[31:0] & m[31:0]};
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic wait_rsp(input int gid, input logic [31:0] es, input logic ec);
      @(posedge clk); #1;
      rv[0] = '0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         chk("busy_add", busy4, 1);
         chk("no_grant_busy", rdy4, 0);
         chk("rsp_valid_timing", vld4, k == 5);
         if (k == 5) begin
            chk("rsp_id", id4, gid);
            chk("rsp_sum", sum4, es);
            chk("rsp_cout", cout4, ec);
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("idle_after_rsp", busy4, 0);
      @(posedge clk); #1;
   endtask

   task automatic run_req(input logic [3:0] mask, input int gid, input logic [31:0] a,
                          input logic [31:0] b, input logic ci, input logic [31:0] es,
                          input logic ec);
      logic [3:0] eg;
      eg = 4'b0001 << gid;
      for (int i = 0; i < 4; i++) begin
         opa[0][i] = a;
         opb[0][i] = b;
      end
      cin[0] = {4{ci}};
      rv[0]  = mask;
      rr[0]  = 1'b1;
      @(negedge clk);
      chk("grant", rdy4, eg);
      chk("busy_at_grant", busy4, 0);
      wait_rsp(gid, es, ec);
   endtask

   task automatic model_step(input int c, input int cyc);
      logic [3:0]  r;
      logic        v, b, co;
      logic [1:0]  id;
      logic [31:0] s;
      logic [3:0]  eg;
      int          nb, g, j;
      nb = (c == 0) ? 4 : 1;
      r  = (c == 0) ? rdy4 : rdy1;
      v  = (c == 0) ? vld4 : vld1;
      b  = (c == 0) ? busy4 : busy1;
      co = (c == 0) ? cout4 : cout1;
      id = (c == 0) ? id4 : id1;
      s  = (c == 0) ? sum4 : {24'd0, sum1};
      seen[c] = r;
      if (!pend[c]) begin
         g = -1;
         for (int k = 0; k < 4; k++) begin
            j = (m_ptr[c] + k) % 4;
            if (g < 0 && rv[c][j]) g = j;
         end
         eg = (g < 0) ? 4'b0000 : (4'b0001 << g);
         chk("rnd_grant", r, eg);
         chk("rnd_idle_valid", v, 0);
         chk("rnd_idle_busy", b, 0);
         if (g >= 0) begin
            pend[c] = 1'b1;
            pid[c]  = g;
            pexp[c] = ref_add(opa[c][g], opb[c][g], cin[c][g], nb);
            m_ptr[c] = (g + 1) % 4;
            gcyc[c] = cyc;
            ngr[c]++;
         end
      end else begin
         chk("rnd_no_grant", r, 0);
         chk("rnd_busy", b, 1);
         chk("rnd_valid", v, (cyc - gcyc[c]) >= nb + 1);
         if (v) begin
            chk("rnd_id", id, pid[c]);
            chk("rnd_sum", s, pexp[c][31:0]);
            chk("rnd_cout", co, pexp[c][32]);
            if (rr[c]) begin
               pend[c] = 1'b0;
               nrs[c]++;
            end
         end
      end
   endtask

   initial begin
      int ng, nr, lastg, cyc;
      int rid;

      tbl[0] = '{4'b0001, 0, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0};
      tbl[1] = '{4'b0100, 2, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
      tbl[2] = '{4'b1011, 3, 32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0};
      tbl[3] = '{4'b1011, 0, 32'h80000000, 32'h80000000, 1'b1, 32'h00000001, 1'b1};
      tbl[4] = '{4'b1110, 1, 32'h00FF00FF, 32'h00010001, 1'b1, 32'h01000101, 1'b0};

      rst = 1'b1;
      for (int c = 0; c < 2; c++) begin
         rv[c]  = 4'hF;
         cin[c] = 4'hF;
         rr[c]  = 1'b1;
         for (int i = 0; i < 4; i++) begin
            opa[c][i] = 32'hFFFFFFFF;
            opb[c][i] = 32'h1;
         end
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_ready4", rdy4, 0);
      chk("rst_ready1", rdy1, 0);
      chk("rst_valid", vld4, 0);
      chk("rst_busy", busy4, 0);
      chk("rst_id", id4, 0);
      chk("rst_sum", sum4, 0);
      chk("rst_cout", cout4, 0);
      chk("rst_busy1", busy1, 0);
      @(posedge clk); #1;
      rst   = 1'b0;
      rv[0] = '0;
      rv[1] = '0;

      for (int t = 0; t < 5; t++)
         run_req(tbl[t].mask, tbl[t].gid, tbl[t].a, tbl[t].b, tbl[t].ci, tbl[t].es, tbl[t].ec);

      // All four requesters valid continuously: grants rotate every 6 cycles.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         opa[0][i] = 32'h11111111 * (i + 1);
         opb[0][i] = 32'hF0F0F0F0 - 32'h01020304 * i;
      end
      cin[0] = 4'b0101;
      rv[0]  = 4'hF;
      rr[0]  = 1'b1;
      ng = 0; nr = 0; lastg = 0; rid = 0;
      for (int cy = 0; cy < 30; cy++) begin
         @(negedge clk);
         if (rdy4 != 4'b0000) begin
            chk("rr_grant", rdy4, 4'b0001 << (ng % 4));
            chk("rr_spacing", cy - lastg, (ng == 0) ? 0 : 6);
            lastg = cy;
            rid   = ng % 4;
            ng++;
         end
         if (vld4) begin
            chk("rr_id", id4, rid);
            chk("rr_sum", {cout4, sum4}, ref_add(opa[0][rid], opb[0][rid], cin[0][rid], 4));
            nr++;
         end
         @(posedge clk); #1;
      end
      rv[0] = '0;
      chk("rr_grant_count", ng, 5);
      chk("rr_rsp_count", nr, 5);
      @(posedge clk); #1;

      // Back-pressure: response held for 5 cycles while requester 1 waits.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         opa[0][i] = 32'h0000FFFF;
         opb[0][i] = 32'h00000001;
      end
      cin[0] = 4'b0000;
      rv[0]  = 4'b0001;
      rr[0]  = 1'b0;
      @(negedge clk);
      chk("bp_first_grant", rdy4, 4'b0001);
      @(posedge clk); #1;
      rv[0] = 4'b0010;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         chk("bp_no_grant", rdy4, 0);
         chk("bp_busy", busy4, 1);
         chk("bp_valid", vld4, k >= 5);
         if (k >= 5) begin
            chk("bp_sum_stable", sum4, 32'h00010000);
            chk("bp_id_stable", id4, 0);
            chk("bp_cout_stable", cout4, 0);
         end
         @(posedge clk); #1;
         if (k == 9) rr[0] = 1'b1;
      end
      @(negedge clk);
      chk("bp_next_grant", rdy4, 4'b0010);
      chk("bp_idle", busy4, 0);
      wait_rsp(1, 32'h00010000, 1'b0);

      // Reset in the middle of ADD drops the request and clears ptr.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         opa[0][i] = 32'h01020304;
         opb[0][i] = 32'h10203040;
      end
      rv[0] = 4'b0100;
      rr[0] = 1'b1;
      @(negedge clk);
      chk("mid_grant", rdy4, 4'b0100);
      @(posedge clk); #1;
      rv[0] = '0;
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("mid_busy_before_rst", busy4, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_ready", rdy4, 0);
      chk("mid_rst_valid", vld4, 0);
      chk("mid_rst_busy", busy4, 0);
      chk("mid_rst_id", id4, 0);
      chk("mid_rst_sum", sum4, 0);
      chk("mid_rst_cout", cout4, 0);
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("mid_no_rsp", vld4, 0);
      end
      @(posedge clk); #1;
      run_req(4'b1010, 1, 32'h01020304, 32'h10203040, 1'b0, 32'h11223344, 1'b0);
      run_req(4'b1000, 3, 32'hDEADBEEF, 32'h21524110, 1'b1, 32'h00000000, 1'b1);

      // Randomized traffic on both widths.
      do_reset();
      for (int c = 0; c < 2; c++) begin
         rv[c] = '0;
         seen[c] = '0;
         m_ptr[c] = 0;
         pend[c] = 1'b0;
         ngr[c] = 0;
         nrs[c] = 0;
         gcyc[c] = 0;
         pid[c] = 0;
         pexp[c] = '0;
      end
      cyc = 0;
      while ((nrs[0] < 4000 || nrs[1] < 6000) && cyc < 60000) begin
         for (int c = 0; c < 2; c++) begin
            rr[c] = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) begin
               if (seen[c][i]) rv[c][i] = 1'b0;
               else if (rv[c][i] && $urandom_range(0, 15) == 0) rv[c][i] = 1'b0;
               else if (!rv[c][i] && $urandom_range(0, 3) == 0) begin
                  opa[c][i] = $urandom;
                  opb[c][i] = $urandom;
                  cin[c][i] = 1'($urandom_range(0, 1));
                  rv[c][i]  = 1'b1;
               end
            end
         end
         @(negedge clk);
         model_step(0, cyc);
         model_step(1, cyc);
         @(posedge clk); #1;
         cyc++;
      end
      chk("rnd_budget", cyc < 60000, 1);
      rv[0] = '0;
      rv[1] = '0;
      rr[0] = 1'b1;
      rr[1] = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         model_step(0, cyc);
         model_step(1, cyc);
         @(posedge clk); #1;
         cyc++;
      end
      for (int c = 0; c < 2; c++) begin
         chk("rnd_one_rsp_per_grant", nrs[c], ngr[c]);
         chk("rnd_drained", pend[c], 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
